// File: rtl/fifo_burst_reader_if.sv
// Byte stream leaving the burst reader: valid/ready handshake with a burst-end tag.
interface fifo_burst_reader_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side controller for fifo_mem: drains the FIFO on threshold, idle timeout or flush
// and re-times the bytes through a 2-entry buffer onto a burst-tagged byte stream.
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_threshold,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd,
    input  logic                  flush,
    fifo_burst_reader_if.master   strm,
    output logic                  busy,
    output logic [15:0]           words_read,
    output logic                  err_underflow
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int ICW = $clog2(TIMEOUT + 1);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              flush_pending;
    logic              flush_clr;
    logic [BCW-1:0]    burst_cnt;
    logic [ICW-1:0]    idle_cnt;
    logic [DATA_W-1:0] buf_data [2];
    logic [1:0]        buf_last;
    logic [1:0]        cnt;
    logic              out_pop;
    logic              last_word;

    // NOTE: fifo_rd is combinational so a pop lands on the same edge the FIFO advances;
    // it depends only on registered state/cnt and fifo_empty, so there is no loop.
    assign fifo_rd   = ((state == BURST) || (state == DRAIN)) && !fifo_empty && (cnt < 2'd2);
    assign last_word = (state == BURST) && (burst_cnt == BCW'(BURST_LEN - 1));
    assign out_pop   = strm.m_valid && strm.m_ready;

    assign strm.m_valid = (cnt != 2'd0);
    assign strm.m_data  = buf_data[0];
    assign strm.m_last  = buf_last[0];
    assign busy         = (state != IDLE) || (cnt != 2'd0);

    // NOTE: every variable gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        flush_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pending) begin
                    if (fifo_empty) flush_clr  = 1'b1;
                    else            state_next = DRAIN;
                end else if (fifo_threshold) begin
                    state_next = BURST;
                end else if (!fifo_empty && (idle_cnt == ICW'(TIMEOUT - 1))) begin
                    state_next = DRAIN;
                end
            end
            BURST: begin
                if (fifo_rd) begin
                    if (last_word) state_next = IDLE;
                end else if (fifo_empty && flush_pending) begin
                    state_next = IDLE;
                    flush_clr  = 1'b1;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                    flush_clr  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            burst_cnt     <= '0;
            idle_cnt      <= '0;
            words_read    <= '0;
            err_underflow <= 1'b0;
            cnt           <= 2'd0;
            // NOTE: the buffer entries are reset too because m_data must read 0 after reset.
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= 2'b00;
        end else begin
            state <= state_next;

            if ((state == IDLE) && (state_next == BURST)) burst_cnt <= '0;
            else if ((state == BURST) && fifo_rd)         burst_cnt <= burst_cnt + 1'b1;

            idle_cnt <= ((state == IDLE) && (state_next == IDLE) && !fifo_empty)
                      ? idle_cnt + 1'b1 : '0;

            // A new request wins over a clear in the same cycle; a repeat while pending is ignored.
            if (flush && !flush_pending) flush_pending <= 1'b1;
            else if (flush_clr)          flush_pending <= 1'b0;

            words_read    <= words_read + 16'(fifo_rd);
            err_underflow <= err_underflow | fifo_underflow;

            case ({fifo_rd, out_pop})
                2'b10: begin
                    buf_data[cnt[0]] <= fifo_data_out;
                    buf_last[cnt[0]] <= last_word;
                    cnt              <= cnt + 2'd1;
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    cnt         <= cnt - 2'd1;
                end
                2'b11: begin
                    // Only reachable at cnt==1: the new word replaces the departing head.
                    buf_data[0] <= fifo_data_out;
                    buf_last[0] <= last_word;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a fifo_mem model feeds it and a scoreboard
// of {last,data} pushed at write time is compared against accepted stream words.
module tb_fifo_burst_reader;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int TIMEOUT   = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  fifo_data_out;
    logic        fifo_empty;
    logic        fifo_threshold;
    logic        fifo_underflow = 1'b0;
    logic        fifo_rd;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] words_read;
    logic        err_underflow;

    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_W(DATA_W)) strm_if ();

    fifo_burst_reader #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_underflow (fifo_underflow),
        .fifo_rd        (fifo_rd),
        .flush          (flush),
        .strm           (strm_if),
        .busy           (busy),
        .words_read     (words_read),
        .err_underflow  (err_underflow)
    );

    // 16x8 first-word-fall-through FIFO model sharing the reader's reset
    logic [7:0] mem [16];
    logic [3:0] rp, wp;
    logic [4:0] count;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    int         thr_level = 4;

    always @(posedge clk) begin
        if (!rst_n) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= wr_data;
                wp      <= wp + 4'd1;
            end
            if (fifo_rd) rp <= rp + 4'd1;
            count <= count + 5'(wr) - 5'(fifo_rd);
        end
    end

    assign fifo_data_out  = mem[rp];
    assign fifo_empty     = (count == 5'd0);
    assign fifo_threshold = (int'(count) >= thr_level);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [8:0] exp_q [$];
    logic [8:0] sb_e;
    int         exp_words = 0;
    int         cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    logic       prev_empty = 1'b1;
    logic       prev_rd = 1'b0;
    int         ne_cyc = 0;
    int         rd_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: handshakes and stalls are judged at the negedge, where inputs
    // and outputs already hold the values the next active edge will see.
    always @(negedge clk) begin
        check("rd_while_empty", 32'(fifo_rd & fifo_empty), 32'd0);
        if (rst_n && prev_stall) begin
            check("hold_data", 32'(strm_if.m_data), 32'(prev_data));
            check("hold_last", 32'(strm_if.m_last), 32'(prev_last));
        end
        if (rst_n && strm_if.m_valid && strm_if.m_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_word", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_data", 32'(strm_if.m_data), 32'(sb_e[7:0]));
                check("sb_last", 32'(strm_if.m_last), 32'(sb_e[8]));
            end
        end
        prev_stall = rst_n && strm_if.m_valid && !strm_if.m_ready;
        prev_data  = strm_if.m_data;
        prev_last  = strm_if.m_last;
        if (!fifo_empty && prev_empty) ne_cyc = cyc;
        if (fifo_rd && !prev_rd)       rd_cyc = cyc;
        prev_empty = fifo_empty;
        prev_rd    = fifo_rd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic last);
        tick();
        wr      = 1'b1;
        wr_data = d;
        exp_q.push_back({last, d});
        exp_words++;
    endtask

    task automatic end_write();
        tick();
        wr = 1'b0;
    endtask

    task automatic write_bursts(input logic [7:0] base);
        for (int i = 1; i <= 8; i++) write_byte(base + 8'(i), (i % BURST_LEN) == 0);
        end_write();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (n < budget && !(exp_q.size() == 0 && !busy && fifo_empty)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        strm_if.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_m_valid", 32'(strm_if.m_valid), 32'd0);
        check("rst_m_last", 32'(strm_if.m_last), 32'd0);
        check("rst_m_data", 32'(strm_if.m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_words", 32'(words_read), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);

        // 1: two full bursts, free-flowing consumer
        strm_if.m_ready = 1'b1;
        write_bursts(8'h00);
        wait_idle(200, "t1_drain");
        check("t1_words", 32'(words_read), 32'(exp_words));
        check("t1_busy", 32'(busy), 32'd0);

        // 2: consumer stalls for 10 cycles after the first accepted word
        fork
            write_bursts(8'h20);
            begin
                int k = 0;
                while (k < 100 && !(strm_if.m_valid && strm_if.m_ready)) begin
                    @(negedge clk);
                    k++;
                end
                check("t2_first_accept", 32'(k < 100), 32'd1);
                tick();
                strm_if.m_ready = 1'b0;
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("t2_rd_low", 32'(fifo_rd), 32'd0);
                check("t2_buf_valid", 32'(strm_if.m_valid), 32'd1);
                tick();
                strm_if.m_ready = 1'b1;
            end
        join
        wait_idle(200, "t2_drain");
        check("t2_words", 32'(words_read), 32'(exp_words));

        // 3: sub-threshold fill drains on the idle timeout
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        write_byte(8'h33, 1'b0);
        end_write();
        wait_idle(200, "t3_drain");
        check("t3_timeout", 32'(rd_cyc - ne_cyc), 32'(TIMEOUT));
        check("t3_words", 32'(words_read), 32'(exp_words));

        // 4: flush aborts a starved burst, later bursts start fresh
        strm_if.m_ready = 1'b0;
        thr_level = 2;
        write_byte(8'hA1, 1'b0);
        write_byte(8'hA2, 1'b0);
        end_write();
        repeat (6) tick();
        check("t4_words", 32'(words_read), 32'(exp_words));
        check("t4_busy", 32'(busy), 32'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        check("t4_rd_low", 32'(fifo_rd), 32'd0);
        strm_if.m_ready = 1'b1;
        wait_idle(50, "t4_busy_fall");
        thr_level = 4;
        write_bursts(8'hB0);
        wait_idle(200, "t4_refill");
        check("t4_words_after", 32'(words_read), 32'(exp_words));

        // 6: sticky underflow error
        tick();
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        check("t6_err_set", 32'(err_underflow), 32'd1);
        repeat (5) tick();
        check("t6_err_held", 32'(err_underflow), 32'd1);

        // 5: reset mid-burst with a full output buffer
        strm_if.m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) write_byte(8'hC0 + 8'(i), i == 4);
        end_write();
        repeat (6) tick();
        check("t5_pre_valid", 32'(strm_if.m_valid), 32'd1);
        check("t5_pre_rd", 32'(fifo_rd), 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        exp_words = 0;
        tick();
        rst_n = 1'b1;
        check("t5_m_valid", 32'(strm_if.m_valid), 32'd0);
        check("t5_words", 32'(words_read), 32'd0);
        check("t5_fifo_rd", 32'(fifo_rd), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_m_data", 32'(strm_if.m_data), 32'd0);
        check("t5_err", 32'(err_underflow), 32'd0);

        strm_if.m_ready = 1'b1;
        write_bursts(8'hD0);
        wait_idle(200, "t5_recover");
        check("t5_words_after", 32'(words_read), 32'(exp_words));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the 16×8 `fifo_mem` FIFO. It pops bytes from the FIFO's first-word-fall-through read port and re-times them through a 2-entry output buffer. Bytes leave on a valid/ready byte stream, grouped into fixed-length bursts tagged with `m_last`. It sits between `fifo_mem` and the downstream consumer, replacing ad-hoc `rd` strobing with threshold, timeout and flush driven draining.

## Interface
- `DATA_W`, 8: byte width; matches `fifo_mem` `data_in`/`data_out`.
- `BURST_LEN`, 4: words per tagged burst; must be ≥1.
- `TIMEOUT`, 32: idle cycles with a non-empty FIFO before a partial drain; must be ≥1.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `fifo_data_out` in DATA_W: FIFO head word, valid whenever `fifo_empty`=0.
- `fifo_empty` in 1: FIFO empty.
- `fifo_threshold` in 1: FIFO fill ≥ threshold.
- `fifo_underflow` in 1: FIFO underflow flag.
- `fifo_rd` out 1: pop strobe to the FIFO `rd` input.
- `flush` in 1: one-cycle request to drain the FIFO completely.
- `m_data` out DATA_W: output byte.
- `m_valid` out 1: `m_data`/`m_last` valid.
- `m_last` out 1: final word of a BURST_LEN burst.
- `m_ready` in 1: consumer accepts when it is high together with `m_valid`.
- `busy` out 1: state≠IDLE or the output buffer is non-empty.
- `words_read` out 16: number of pops since reset; wraps modulo 2^16.
- `err_underflow` out 1: sticky; set when `fifo_underflow`=1 is sampled.

## Operation
- Output buffer: 2-entry FIFO of {data,last}; `cnt` ∈ 0..2; its head drives `m_data`/`m_last`; `m_valid`=(`cnt`≠0).
- Pop rule: `fifo_rd` = (state∈{BURST,DRAIN}) & !`fifo_empty` & (`cnt`<2). Combinational from registered state/`cnt` and `fifo_empty`.
- On a pop edge, `fifo_data_out` is pushed into the buffer and `words_read`++.
- `fifo_rd` is never high while `fifo_empty`=1.
- `flush_pending`: set by `flush`, cleared as stated below. A `flush` arriving while pending is a no-op.
- `idle_cnt`: increments in IDLE while !`fifo_empty`. It is zeroed whenever `fifo_empty`=1 or on leaving IDLE.
- IDLE transitions, in priority order:
  - `flush_pending` & `fifo_empty` → stay IDLE, clear `flush_pending`.
  - `flush_pending` & !`fifo_empty` → DRAIN.
  - `fifo_threshold` → BURST with `burst_cnt`=0.
  - `idle_cnt`==TIMEOUT-1 & !`fifo_empty` → DRAIN.
- BURST:
  - Each pop increments `burst_cnt`.
  - The pop with `burst_cnt`==BURST_LEN-1 is pushed with last=1 → IDLE.
  - If `fifo_empty` and no pop: if `flush_pending` → IDLE, clear `flush_pending`, abort burst (no `m_last`); otherwise stall in BURST.
- DRAIN:
  - Pops carry last=0.
  - First cycle with `fifo_empty`=1 → IDLE, clear `flush_pending`.
- `err_underflow` is cleared only by reset.

## Timing
- Reset (synchronous, `rst_n`=0 at an edge): the next cycle has state=IDLE, `cnt`=0, all counters 0, `flush_pending`=0, `err_underflow`=0.
  - All outputs are 0 after reset: `fifo_rd`, `m_valid`, `m_last`, `m_data`=0, `busy`, `words_read`.
  - Buffered words are discarded on mid-operation reset.
- Latency: a pop at edge N makes the word visible on `m_data` with `m_valid`=1 after edge N (same cycle the FIFO advances).
- First pop: with state entering BURST at edge N, `fifo_rd` can be high in cycle N+1.
- Throughput: 1 word/cycle sustained when `m_ready`=1 every cycle.
- Backpressure: with `m_ready`=0, at most 2 words are popped before `fifo_rd` drops.
- Simultaneous buffer push and pop at `cnt`=2: `fifo_rd` is not issued (`cnt`<2 rule). At `cnt`=1, push+pop leaves `cnt`=1.
- `m_data`/`m_last` are held stable while `m_valid`=1 & `m_ready`=0.
- `words_read` wraps 0xFFFF → 0x0000.

## Test plan
1. Write 0x01..0x08 into `fifo_mem` (threshold asserts), `m_ready`=1 → two bursts, bytes 0x01..0x08 in order; `m_last`=1 only on 0x04 and 0x08; `words_read`=8; `busy`=0 afterwards.
2. Same as 1, with `m_ready`=0 for 10 cycles after the first accepted word → `fifo_rd` low once `cnt`=2; no lost or duplicated bytes; `m_data` stable while stalled.
3. Write 0x11,0x22,0x33, threshold never asserts → DRAIN begins TIMEOUT=32 cycles after the FIFO goes non-empty; 3 words out with `m_last`=0; state returns to IDLE.
4. BURST with 2 of 4 words popped and FIFO empty, pulse `flush` → IDLE within 2 cycles, no `m_last`; `busy` falls once both words are consumed; a later write of 8 bytes gives normal bursts.
5. Assert `rst_n`=0 for one edge mid-burst with `cnt`=2 → next cycle `m_valid`=0, `words_read`=0, `fifo_rd`=0, state IDLE.
6. Drive `fifo_underflow`=1 for one cycle → `err_underflow`=1 and held until reset. Across all tests, assertion: `fifo_rd` & `fifo_empty` never true.
